// File: rtl/l1_circular_buffer_q_if.sv
// Bunch-crossing data, trigger and readout handshake bundle for the L1 circular buffer.
interface l1_circular_buffer_q_if #(
  parameter int DATA_WIDTH = 29,
  parameter int ADDR_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] din;
  logic                  inHit;
  logic                  L1A;
  logic [ADDR_WIDTH-1:0] latencyL1A;
  logic                  rdReady;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  hit;
  logic                  doutValid;
  logic                  l1aOverflow;
  logic                  latencyErr;

  modport master (
    output din, inHit, L1A, latencyL1A, rdReady,
    input  wrAddr, dout, hit, doutValid, l1aOverflow, latencyErr
  );

  modport slave (
    input  din, inHit, L1A, latencyL1A, rdReady,
    output wrAddr, dout, hit, doutValid, l1aOverflow, latencyErr
  );
endinterface

// File: rtl/l1_circular_buffer_q.sv
// L1 trigger latency buffer: every bunch crossing is written into a circular store,
// each L1A queues a look-back address that a two-stage pipeline reads out downstream.
module l1_circular_buffer_q #(
  parameter int DATA_WIDTH = 29,
  parameter int ADDR_WIDTH = 9,
  parameter int QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  l1_circular_buffer_q_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int QAW   = $clog2(QDEPTH);
  localparam logic [QAW:0]          PTR_ONE  = {{QAW{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wrAddr_r;
  logic [DEPTH-1:0]      bitmap_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] queue_r [QDEPTH];
  logic [QAW:0]          wrPtr_r;
  logic [QAW:0]          rdPtr_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  hit_r;
  logic                  doutValid_r;
  logic                  l1aOverflow_r;
  logic                  latencyErr_r;

  logic                  qEmpty_s;
  logic                  qFull_s;
  logic                  latZero_s;
  logic                  pushReq_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  headHit_s;
  logic [ADDR_WIDTH-1:0] rdAddr_s;
  logic [ADDR_WIDTH-1:0] headAddr_s;

  // Queue status, S1 pop decision and push acceptance for the current cycle.
  always_comb begin
    qEmpty_s   = (wrPtr_r == rdPtr_r);
    qFull_s    = (wrPtr_r[QAW] != rdPtr_r[QAW]) && (wrPtr_r[QAW-1:0] == rdPtr_r[QAW-1:0]);
    latZero_s  = (bus.latencyL1A == {ADDR_WIDTH{1'b0}});
    pushReq_s  = bus.L1A && !latZero_s;
    pop_s      = !qEmpty_s && (!doutValid_r || bus.rdReady);
    push_s     = pushReq_s && (!qFull_s || pop_s);
    rdAddr_s   = wrAddr_r - bus.latencyL1A;
    headAddr_s = queue_r[rdPtr_r[QAW-1:0]];
    headHit_s  = bitmap_r[headAddr_s];
  end

  // Data memory and pending-address slots; validity comes from the bitmap and queue pointers.
  always_ff @(posedge clk) begin
    if (reset && bus.inHit) begin
      mem_r[wrAddr_r] <= bus.din;
    end
    if (reset && push_s) begin
      queue_r[wrPtr_r[QAW-1:0]] <= rdAddr_s;
    end
  end

  // Write pointer, hit bitmap, queue pointers, sticky flags and the S2 output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrAddr_r      <= {ADDR_WIDTH{1'b0}};
      bitmap_r      <= {DEPTH{1'b0}};
      wrPtr_r       <= {(QAW+1){1'b0}};
      rdPtr_r       <= {(QAW+1){1'b0}};
      dout_r        <= {DATA_WIDTH{1'b0}};
      hit_r         <= 1'b0;
      doutValid_r   <= 1'b0;
      l1aOverflow_r <= 1'b0;
      latencyErr_r  <= 1'b0;
    end else begin
      wrAddr_r           <= wrAddr_r + ADDR_ONE;
      bitmap_r[wrAddr_r] <= bus.inHit;
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (pushReq_s && !push_s) begin
        l1aOverflow_r <= 1'b1;
      end
      if (bus.L1A && latZero_s) begin
        latencyErr_r <= 1'b1;
      end
      // A same-cycle write to headAddr_s lands after this read, so old contents are returned.
      if (pop_s) begin
        rdPtr_r     <= rdPtr_r + PTR_ONE;
        hit_r       <= headHit_s;
        dout_r      <= headHit_s ? mem_r[headAddr_s] : {DATA_WIDTH{1'b0}};
        doutValid_r <= 1'b1;
      end else if (bus.rdReady) begin
        doutValid_r <= 1'b0;
      end
    end
  end

  assign bus.wrAddr      = wrAddr_r;
  assign bus.dout        = dout_r;
  assign bus.hit         = hit_r;
  assign bus.doutValid   = doutValid_r;
  assign bus.l1aOverflow = l1aOverflow_r;
  assign bus.latencyErr  = latencyErr_r;
endmodule
